// File: rtl/regfile_alu_datapath.sv
// rtl/regfile_alu_datapath.sv - 8x8 register file, operand-2 select and 8-bit ALU for the execute stage
module regfile_alu_datapath #(
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1,
  parameter int ADD_DELAY   = 2,
  parameter int LOGIC_DELAY = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       WRITEENABLE,
  input  logic [2:0] WRITEREG,
  input  logic [2:0] READREG1,
  input  logic [2:0] READREG2,
  input  logic [2:0] ALUOP,
  input  logic       SIGN,
  input  logic       IMMEDIATE,
  input  logic [7:0] IMMVAL,
  output logic [7:0] REGOUT1,
  output logic [7:0] REGOUT2,
  output logic [7:0] ALURESULT
);

  // The delay parameters describe gate timing seen in behavioural models of
  // this stage; this RTL is zero-delay, so they only need to be non-negative.
  if (READ_DELAY < 0 || WRITE_DELAY < 0 || ADD_DELAY < 0 || LOGIC_DELAY < 0) begin : g_negative_delay
  end

  localparam logic [2:0] OP_FORWARD = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_AND     = 3'b010;
  localparam logic [2:0] OP_OR      = 3'b011;

  logic [7:0] regs_q [8];
  logic [7:0] regs_d [8];
  logic [7:0] op2_neg;
  logic [7:0] op2;

  // Asynchronous reads straight from the register array.
  assign REGOUT1 = regs_q[READREG1];
  assign REGOUT2 = regs_q[READREG2];

  // Operand 2: immediate wins over negation; negation is two's complement mod 256.
  always_comb begin
    op2_neg = ~REGOUT2 + 8'd1;
    op2     = REGOUT2;
    if (IMMEDIATE) begin
      op2 = IMMVAL;
    end else if (SIGN) begin
      op2 = op2_neg;
    end
  end

  // ALU: carry/overflow dropped; reserved opcodes produce zero.
  always_comb begin
    ALURESULT = 8'h00;
    case (ALUOP)
      OP_FORWARD: ALURESULT = op2;
      OP_ADD:     ALURESULT = REGOUT1 + op2;
      OP_AND:     ALURESULT = REGOUT1 & op2;
      OP_OR:      ALURESULT = REGOUT1 | op2;
      default:    ALURESULT = 8'h00;
    endcase
  end

  // Next register state: reset clears all, otherwise optional write-back of the ALU result.
  always_comb begin
    regs_d = regs_q;
    if (RESET) begin
      for (int i = 0; i < 8; i++) begin
        regs_d[i] = 8'h00;
      end
    end else if (WRITEENABLE) begin
      regs_d[WRITEREG] = ALURESULT;
    end
  end

  // Register array update on the rising clock edge.
  always_ff @(posedge CLK) begin
    regs_q <= regs_d;
  end

endmodule

// File: tb/tb_regfile_alu_datapath.sv
// tb/tb_regfile_alu_datapath.sv - directed self-checking bench for regfile_alu_datapath
module tb_regfile_alu_datapath;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       WRITEENABLE;
  logic [2:0] WRITEREG;
  logic [2:0] READREG1;
  logic [2:0] READREG2;
  logic [2:0] ALUOP;
  logic       SIGN;
  logic       IMMEDIATE;
  logic [7:0] IMMVAL;
  logic [7:0] REGOUT1;
  logic [7:0] REGOUT2;
  logic [7:0] ALURESULT;

  int checks = 0;
  int errors = 0;

  regfile_alu_datapath dut (
    .CLK(CLK),
    .RESET(RESET),
    .WRITEENABLE(WRITEENABLE),
    .WRITEREG(WRITEREG),
    .READREG1(READREG1),
    .READREG2(READREG2),
    .ALUOP(ALUOP),
    .SIGN(SIGN),
    .IMMEDIATE(IMMEDIATE),
    .IMMVAL(IMMVAL),
    .REGOUT1(REGOUT1),
    .REGOUT2(REGOUT2),
    .ALURESULT(ALURESULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic loadi(input logic [2:0] rd, input logic [7:0] val);
    IMMEDIATE   = 1'b1;
    SIGN        = 1'b0;
    ALUOP       = 3'b000;
    IMMVAL      = val;
    WRITEREG    = rd;
    WRITEENABLE = 1'b1;
    tick();
    WRITEENABLE = 1'b0;
    IMMEDIATE   = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [2:0] idx, input logic [7:0] exp);
    READREG1 = idx;
    READREG2 = idx;
    #1;
    check({tag, "_r1"}, REGOUT1, exp);
    check({tag, "_r2"}, REGOUT2, exp);
  endtask

  task automatic set_alu(input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] op,
                         input logic sgn, input logic imm, input logic [7:0] iv);
    READREG1  = r1;
    READREG2  = r2;
    ALUOP     = op;
    SIGN      = sgn;
    IMMEDIATE = imm;
    IMMVAL    = iv;
    #1;
  endtask

  initial begin
    RESET = 1'b1; WRITEENABLE = 1'b0; WRITEREG = 3'd0; READREG1 = 3'd0; READREG2 = 3'd0;
    ALUOP = 3'b000; SIGN = 1'b0; IMMEDIATE = 1'b0; IMMVAL = 8'h00;
    #2;

    // Reset clears every register
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read_check($sformatf("reset_r%0d", i), 3'(i), 8'h00);
    end

    // Reset has priority over a simultaneous write, held for two cycles
    loadi(3'd3, 8'h77);
    read_check("pre_reset_r3", 3'd3, 8'h77);
    RESET = 1'b1; WRITEENABLE = 1'b1; IMMEDIATE = 1'b1; IMMVAL = 8'hAA; WRITEREG = 3'd3;
    tick();
    tick();
    RESET = 1'b0; WRITEENABLE = 1'b0; IMMEDIATE = 1'b0;
    read_check("reset_vs_write_r3", 3'd3, 8'h00);

    // LOADI
    loadi(3'd4, 8'h05);
    loadi(3'd2, 8'h09);
    read_check("loadi_r4", 3'd4, 8'h05);
    read_check("loadi_r2", 3'd2, 8'h09);

    // ADD r6 = r4 + r2
    set_alu(3'd4, 3'd2, 3'b001, 1'b0, 1'b0, 8'h00);
    check("add_result", ALURESULT, 8'h0E);
    WRITEREG = 3'd6; WRITEENABLE = 1'b1;
    tick();
    WRITEENABLE = 1'b0;
    read_check("add_r6", 3'd6, 8'h0E);

    // SUB 5 - 9
    set_alu(3'd4, 3'd2, 3'b001, 1'b1, 1'b0, 8'h00);
    check("sub_neg", ALURESULT, 8'hFC);
    WRITEREG = 3'd5; WRITEENABLE = 1'b1;
    tick();
    WRITEENABLE = 1'b0;
    read_check("sub_r5", 3'd5, 8'hFC);

    // SUB 9 - 5
    loadi(3'd4, 8'h09);
    loadi(3'd2, 8'h05);
    set_alu(3'd4, 3'd2, 3'b001, 1'b1, 1'b0, 8'h00);
    check("sub_pos", ALURESULT, 8'h04);

    // IMMEDIATE overrides SIGN: 9 + 3
    set_alu(3'd4, 3'd2, 3'b001, 1'b1, 1'b1, 8'h03);
    check("imm_over_sign", ALURESULT, 8'h0C);

    // ADD wrap-around
    loadi(3'd4, 8'hFF);
    loadi(3'd2, 8'h02);
    set_alu(3'd4, 3'd2, 3'b001, 1'b0, 1'b0, 8'h00);
    check("add_wrap", ALURESULT, 8'h01);

    // AND / OR / MOV
    loadi(3'd4, 8'h0C);
    loadi(3'd2, 8'h0A);
    set_alu(3'd4, 3'd2, 3'b010, 1'b0, 1'b0, 8'h00);
    check("and", ALURESULT, 8'h08);
    set_alu(3'd4, 3'd2, 3'b011, 1'b0, 1'b0, 8'h00);
    check("or", ALURESULT, 8'h0E);
    set_alu(3'd4, 3'd2, 3'b000, 1'b0, 1'b0, 8'h00);
    check("mov_result", ALURESULT, 8'h0A);
    WRITEREG = 3'd7; WRITEENABLE = 1'b1;
    tick();
    WRITEENABLE = 1'b0;
    read_check("mov_r7", 3'd7, 8'h0A);

    // Reserved opcodes
    set_alu(3'd4, 3'd2, 3'b100, 1'b0, 1'b0, 8'h00);
    check("op100", ALURESULT, 8'h00);
    set_alu(3'd4, 3'd2, 3'b111, 1'b0, 1'b1, 8'hFF);
    check("op111", ALURESULT, 8'h00);

    // Negation corner cases through FORWARD
    loadi(3'd2, 8'h80);
    set_alu(3'd0, 3'd2, 3'b000, 1'b1, 1'b0, 8'h00);
    check("neg_80", ALURESULT, 8'h80);
    loadi(3'd2, 8'h00);
    set_alu(3'd0, 3'd2, 3'b000, 1'b1, 1'b0, 8'h00);
    check("neg_00", ALURESULT, 8'h00);
    loadi(3'd2, 8'h01);
    set_alu(3'd0, 3'd2, 3'b000, 1'b1, 1'b0, 8'h00);
    check("neg_01", ALURESULT, 8'hFF);

    // Write gating over several edges
    loadi(3'd1, 8'h11);
    IMMEDIATE = 1'b1; SIGN = 1'b0; ALUOP = 3'b000; IMMVAL = 8'h55; WRITEREG = 3'd1; WRITEENABLE = 1'b0;
    #1;
    check("gate_result", ALURESULT, 8'h55);
    tick();
    tick();
    tick();
    IMMEDIATE = 1'b0;
    read_check("gate_r1", 3'd1, 8'h11);

    // RESET pulse between edges does nothing
    RESET = 1'b1;
    #3;
    RESET = 1'b0;
    tick();
    read_check("reset_no_edge_r1", 3'd1, 8'h11);

    // Read-modify-write r3 <- r3 + r3
    loadi(3'd3, 8'h03);
    set_alu(3'd3, 3'd3, 3'b001, 1'b0, 1'b0, 8'h00);
    check("rmw_old_read", REGOUT1, 8'h03);
    check("rmw_result", ALURESULT, 8'h06);
    WRITEREG = 3'd3; WRITEENABLE = 1'b1;
    tick();
    WRITEENABLE = 1'b0;
    read_check("rmw_r3", 3'd3, 8'h06);

    // r0 is an ordinary writable register
    loadi(3'd0, 8'h3C);
    read_check("r0_write", 3'd0, 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
